sync: RTL and testbench

- 3-bit synchronous binary up-counter. All three stages are clocked by the same clock edge; there is no ripple clocking.
- Built from toggle-style stages: each bit toggles when enable is high and all lower bits are 1.
- Used as a lab-level counter primitive. Its count outputs drive displays or downstream logic directly.

---
 rtl/sync.sv | 55 +++++
 tb/tb_sync.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sync.sv
// -----------------------------------------------------------------------------
// sync : 3-bit synchronous binary up-counter built from toggle stages.
//
// Ports
//   Y0      output  count bit 0 (LSB), driven straight from its flop
//   Y1      output  count bit 1, driven straight from its flop
//   Y2      output  count bit 2 (MSB), driven straight from its flop
//   clock   input   rising-edge clock shared by every stage
//   clear   input   asynchronous active-low clear, forces the count to 000
//   enable  input   count enable, sampled only at the rising clock edge
//
// Interface timing: there is no handshake. The count is valid one
// clock-to-Q after each rising edge, and immediately after clear falls.
// The count wraps 111 -> 000 without a terminal-count output.
// -----------------------------------------------------------------------------
module sync (
    output logic Y0,
    output logic Y1,
    output logic Y2,
    input  logic clock,
    input  logic clear,
    input  logic enable
);

    // Stage state, bit 0 is the LSB.
    logic [2:0] q;

    // Toggle requests. A stage flips when every lower stage is 1, which is
    // what makes the chain an up-counter while all stages share one clock.
    logic t0;
    logic t1;
    logic t2;

    always_comb begin
        t0 = enable;
        t1 = enable & q[0];
        t2 = enable & q[0] & q[1];
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            q <= 3'b000;
        end else begin
            q[0] <= q[0] ^ t0;
            q[1] <= q[1] ^ t1;
            q[2] <= q[2] ^ t2;
        end
    end

    // Outputs come directly from the flops so they never glitch.
    assign Y0 = q[0];
    assign Y1 = q[1];
    assign Y2 = q[2];

endmodule

// File: tb/tb_sync.sv
// -----------------------------------------------------------------------------
// tb_sync : self-checking bench for the sync 3-bit up-counter.
// The driver applies stimulus, advances a plain-arithmetic model of the
// count and pushes the expected value into exp_q; a separate monitor pops
// and compares each time the driver signals that the DUT output is due.
// -----------------------------------------------------------------------------
module tb_sync;

    // ---------------- clock / reset ----------------
    logic clock;
    logic clear;
    logic enable;
    logic Y0;
    logic Y1;
    logic Y2;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    sync dut (
        .Y0     (Y0),
        .Y1     (Y1),
        .Y2     (Y2),
        .clock  (clock),
        .clear  (clear),
        .enable (enable)
    );

    // ---------------- scoreboard ----------------
    logic [2:0] exp_q[$];
    int         checks;
    int         errors;
    int         model;          // reference count, 0..7
    string      cur_tag;
    event       sample_ev;

    // Monitor: every sample event consumes one expected value.
    initial begin
        logic [2:0] exp_v;
        logic [2:0] got;
        forever begin
            @(sample_ev);
            got = {Y2, Y1, Y0};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s: output %b sampled with no expected value queued", cur_tag, got);
            end else begin
                exp_v = exp_q.pop_front();
                if (got !== exp_v) begin
                    errors++;
                    $display("FAIL %s: got %b expected %b at %0t", cur_tag, got, exp_v, $time);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic expect_now(input string tag);
        logic [2:0] e;
        e = 3'(model);
        cur_tag = tag;
        exp_q.push_back(e);
        ->sample_ev;
        #0;
    endtask

    // One rising edge with the given enable; check just after the edge.
    task automatic step(input logic en, input string tag);
        enable = en;
        @(posedge clock);
        if (clear && en) model = (model + 1) % 8;
        #1;
        expect_now(tag);
    endtask

    // Enable pulses high between edges but is low at the edge: must hold.
    task automatic step_glitch(input string tag);
        enable = 1'b1;
        #2;
        enable = 1'b0;
        @(posedge clock);
        #1;
        expect_now(tag);
    endtask

    // Pulse clear low between edges and check the count drops without an edge.
    task automatic pulse_clear(input string tag);
        clear = 1'b0;
        #1;
        model = 0;
        expect_now(tag);
        #1;
        clear = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks = 0;
        errors = 0;
        model  = 0;
        enable = 1'b0;
        clear  = 1'b1;

        // Reset with clock idle (well before the first edge at t=5).
        #1 clear = 1'b0;
        #1;
        expect_now("reset_async");

        // Held in reset while enabled edges arrive.
        for (int i = 0; i < 3; i++) step(1'b1, "reset_hold");

        // Release and count through a wrap.
        clear = 1'b1;
        for (int i = 0; i < 9; i++) step(1'b1, "count_wrap");     // ends at 001

        // Hold at 011.
        for (int i = 0; i < 2; i++) step(1'b1, "to_011");
        for (int i = 0; i < 4; i++) step(1'b0, "hold_011");
        step(1'b1, "resume_100");

        // Enable changes between edges have no effect.
        step_glitch("enable_between_edges");

        // Async clear mid-count at 101.
        step(1'b1, "to_101");
        pulse_clear("clear_mid_count");
        for (int i = 0; i < 2; i++) step(1'b1, "after_clear");  // ends at 010

        // Long run: two full cycles from 000.
        pulse_clear("clear_before_long");
        for (int i = 0; i < 16; i++) step(1'b1, "long_run");

        // Alternating enable from 000: ends at 100.
        pulse_clear("clear_before_alt");
        for (int i = 0; i < 8; i++) step((i % 2) == 0, "alt_enable");

        // Randomised enables with occasional asynchronous clears.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0) pulse_clear("rand_clear");
            step(1'($urandom_range(0, 1)), "rand_step");
        end

        // Every queued expectation must have been consumed.
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
